// File: rtl/br_predict_btb.sv
// Tagged branch target buffer with a 2-bit saturating direction counter per entry.
// Combinational lookup for fetch, single training port from execute, plus branch/mispredict counters.
module br_predict_btb #(
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 8,
  parameter int STAT_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic              pred_hit,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_mispredict,
  input  logic              clear,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int ENTRIES = 2 ** IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  logic [ENTRIES-1:0] valid_q, valid_d;
  tag_t               tag_q    [ENTRIES];
  tag_t               tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [STAT_W-1:0]  stat_br_q, stat_br_d;
  logic [STAT_W-1:0]  stat_mis_q, stat_mis_d;

  idx_t if_idx, upd_idx;
  tag_t if_tag, upd_tag;
  logic upd_hit;
  logic unused_pc;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  // Byte-offset and high PC bits carry no index or tag information.
  assign unused_pc = ^{if_pc, upd_pc};

  // Lookup sees registered state only, so a same-cycle update is not bypassed.
  assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = pred_hit && ctr_q[if_idx][1];
  assign pred_target = pred_hit ? target_q[if_idx] : 32'h0;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mis_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    valid_d    = valid_q;
    tag_d      = tag_q;
    target_d   = target_q;
    ctr_d      = ctr_q;
    stat_br_d  = stat_br_q + STAT_W'(upd_valid);
    stat_mis_d = stat_mis_q + STAT_W'(upd_valid & upd_mispredict);

    if (clear) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_d[upd_idx]    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = upd_target;
        end else begin
          ctr_d[upd_idx]    = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Only taken misses allocate; the new entry starts weakly taken.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!nRST) begin
      valid_q    <= '0;
      stat_br_q  <= '0;
      stat_mis_q <= '0;
      // NOTE: the entry arrays are reset explicitly, so they map to flops rather than a RAM macro.
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      ctr_q      <= ctr_d;
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

endmodule

// File: tb/tb_br_predict_btb.sv
// Bench for br_predict_btb: table-driven cycles with a scoreboard queue of expected lookup/stat values,
// plus a statistics/reset sequence that also exercises a narrow STAT_W=4 instance.
module tb_br_predict_btb;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] if_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
  logic        clear = 1'b0;

  logic        pred_taken, pred_hit;
  logic [31:0] pred_target, stat_branches, stat_mispred;
  logic        n_taken, n_hit;
  logic [31:0] n_target;
  logic [3:0]  n_branches, n_mispred;

  br_predict_btb #(.IDX_W(4), .TAG_W(8), .STAT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .clear(clear),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  br_predict_btb #(.IDX_W(4), .TAG_W(8), .STAT_W(4)) dut_narrow (
    .CLK(CLK), .nRST(nRST), .if_pc(if_pc),
    .pred_taken(n_taken), .pred_target(n_target), .pred_hit(n_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .clear(clear),
    .stat_branches(n_branches), .stat_mispred(n_mispred)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        um;
    logic        clr;
    logic [31:0] ipc;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
    logic [31:0] ebr;
    logic [31:0] emis;
  } vec_t;

  typedef struct {
    string       name;
    logic        h;
    logic        t;
    logic [31:0] tgt;
    logic [31:0] br;
    logic [31:0] mis;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utgt, input logic um, input logic clr,
                              input logic [31:0] ipc, input logic eh, input logic et,
                              input logic [31:0] etgt, input logic [31:0] ebr,
                              input logic [31:0] emis);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.um = um; v.clr = clr;
    v.ipc = ipc; v.eh = eh; v.et = et; v.etgt = etgt; v.ebr = ebr; v.emis = emis;
    return v;
  endfunction

  // Drive one cycle, queue its expectation, compare lookup/stats mid-cycle, then let the edge commit.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    exp_t got;
    upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut; upd_target = v.utgt;
    upd_mispredict = v.um; clear = v.clr; if_pc = v.ipc;
    e.name = name; e.h = v.eh; e.t = v.et; e.tgt = v.etgt; e.br = v.ebr; e.mis = v.emis;
    sb_q.push_back(e);
    @(negedge CLK);
    got = sb_q.pop_front();
    check({got.name, ".hit"},    32'(pred_hit),   32'(got.h));
    check({got.name, ".taken"},  32'(pred_taken), 32'(got.t));
    check({got.name, ".target"}, pred_target,     got.tgt);
    check({got.name, ".br"},     stat_branches,   got.br);
    check({got.name, ".mis"},    stat_mispred,    got.mis);
    @(posedge CLK); #1;
  endtask

  task automatic run_tbl(input string grp);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("%s[%0d]", grp, i));
    tbl.delete();
  endtask

  task automatic do_reset();
    nRST = 1'b0; upd_valid = 1'b0; clear = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int mis_cnt;
    logic mis;
    @(posedge CLK); #1;

    // Reset state, training on 0x40, decrement through weak-NT to strong-NT and floor saturation.
    do_reset();
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h40, 1, 32'h100, 1, 0, 32'h40, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h40, 0, 0, 1, 0, 32'h40, 1, 1, 32'h100, 1, 1));
    tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 32'h40, 1, 0, 32'h100, 2, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h40, 1, 0, 32'h100, 3, 2));
    tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 32'h40, 1, 0, 32'h100, 3, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h40, 1, 0, 32'h100, 4, 2));
    run_tbl("basic");

    // Aliasing: 0x80 shares index 0 with 0x40 but has a different tag.
    do_reset();
    tbl.push_back(mk(1, 32'h40, 1, 32'h100, 0, 0, 32'h80, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h80, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 32'h80, 1, 32'h200, 0, 0, 32'h40, 1, 1, 32'h100, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h80, 1, 1, 32'h200, 2, 0));
    tbl.push_back(mk(1, 32'h40, 0, 32'h999, 0, 0, 32'h80, 1, 1, 32'h200, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h80, 1, 1, 32'h200, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0, 3, 0));
    run_tbl("alias");

    // Saturation at strong-taken, target refresh on a taken hit, pc[1:0] ignored.
    do_reset();
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 32'h80, 1, 32'h300, 0, 0, 32'h80, i != 0, i != 0,
                       (i != 0) ? 32'h300 : 32'h0, i, 0));
    tbl.push_back(mk(1, 32'h80, 0, 0, 0, 0, 32'h80, 1, 1, 32'h300, 5, 0));
    tbl.push_back(mk(1, 32'h80, 0, 0, 0, 0, 32'h80, 1, 1, 32'h300, 6, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h80, 1, 0, 32'h300, 7, 0));
    tbl.push_back(mk(1, 32'h80, 1, 32'h340, 0, 0, 32'h80, 1, 0, 32'h300, 7, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h83, 1, 1, 32'h340, 8, 0));
    run_tbl("sat");

    // Same-cycle lookup/update (no bypass), then clear beating a taken miss.
    do_reset();
    tbl.push_back(mk(1, 32'h40, 1, 32'h100, 1, 0, 32'h40, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h40, 0, 0, 1, 0, 32'h40, 1, 1, 32'h100, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h40, 1, 0, 32'h100, 2, 2));
    tbl.push_back(mk(1, 32'h84, 1, 32'h400, 0, 1, 32'h40, 1, 0, 32'h100, 2, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h84, 0, 0, 0, 3, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0, 3, 2));
    run_tbl("same");

    // Statistics: 17 updates with mispredicts at 2, 5, 9 (so 10/3 after ten), narrow counter wraps.
    do_reset();
    mis_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      mis = (i == 2) || (i == 5) || (i == 9);
      apply(mk(1, 32'(i * 4), i[0], 32'h1000 + 32'(i * 16), mis, 0, 32'h0, 0, 0, 0,
               32'(i), 32'(mis_cnt)), $sformatf("stat[%0d]", i));
      if (mis) mis_cnt++;
    end
    apply(mk(0, 0, 0, 0, 0, 0, 32'h4, 1, 1, 32'h1010, 17, 3), "stat_end");
    @(negedge CLK);
    check("narrow.br",  32'(n_branches), 32'd1);
    check("narrow.mis", 32'(n_mispred),  32'd3);
    @(posedge CLK); #1;

    // Reset mid-run with a concurrent clear and taken update: reset wins, all state discarded.
    nRST = 1'b0; clear = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h500; upd_mispredict = 1'b1;
    @(posedge CLK); #1;
    nRST = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0, 0, 0), "rst_mid.a");
    apply(mk(0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0, 0, 0), "rst_mid.b");
    @(negedge CLK);
    check("rst_mid.narrow_br", 32'(n_branches), 32'd0);
    @(posedge CLK); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
